// File: rtl/ps2_host_tx_if.sv
// CPU-side bus of the PS/2 host transmitter.
//   STB  : bus select            WE   : write enable (valid with STB)
//   din  : write data, [7:0] = command byte to send
//   ACK  : acknowledge (follows STB)
//   dout : status {28'b0, timeout, error, done, busy}
//   INT  : done | error | timeout
interface ps2_host_tx_if;
  logic        STB;
  logic        WE;
  logic [31:0] din;
  logic        ACK;
  logic [31:0] dout;
  logic        INT;

  modport master (output STB, WE, din, input ACK, dout, INT);
  modport slave  (input STB, WE, din, output ACK, dout, INT);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard over
// the open-drain PS2C/PS2D pair: inhibit, request-to-send, shift data/parity/stop
// on device clock falls, then check the device ACK.
//   clk_scan : sole clock          reset   : synchronous, active-high
//   bus      : CPU slave port (STB/WE/din/ACK/dout/INT)
//   busy     : transmission in progress (receiver discards bytes while high)
//   ps2c_i   : PS2C pad input      ps2d_i  : PS2D pad input (both asynchronous)
//   ps2c_oe  : 1 = pull PS2C low   ps2d_oe : 1 = pull PS2D low
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic          clk_scan,
  input  logic          reset,
  ps2_host_tx_if.slave  bus,
  output logic          busy,
  input  logic          ps2c_i,
  input  logic          ps2d_i,
  output logic          ps2c_oe,
  output logic          ps2d_oe
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned FILT_W  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned INH_PRE_I = (INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0;

  localparam logic [CNT_W-1:0]  INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  INH_PRE   = CNT_W'(INH_PRE_I);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INHIBIT  = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_XFER     = 3'd3;
  localparam logic [2:0] S_WAIT_ACK = 3'd4;
  localparam logic [2:0] S_RELEASE  = 3'd5;

  // Pad synchronisers and PS2C glitch filter
  logic              c_meta_q, c_sync_q, d_meta_q, d_sync_q;
  logic              filt_q, filt_prev_q;
  logic [FILT_W-1:0] fcnt_q;
  logic              fall_c;

  always_ff @(posedge clk_scan) begin
    if (reset) begin
      c_meta_q    <= 1'b1;
      c_sync_q    <= 1'b1;
      d_meta_q    <= 1'b1;
      d_sync_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      c_meta_q    <= ps2c_i;
      c_sync_q    <= c_meta_q;
      d_meta_q    <= ps2d_i;
      d_sync_q    <= d_meta_q;
      filt_prev_q <= filt_q;
      // Filtered clock flips only after FILTER_LEN consecutive differing samples
      if (c_sync_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FILT_LAST) begin
        filt_q <= c_sync_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FILT_W'(1);
      end
    end
  end

  assign fall_c = filt_prev_q & ~filt_q;

  // Transmit FSM and status
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [9:0]       frame_q, frame_d;
  logic             c_oe_q, c_oe_d, d_oe_q, d_oe_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             error_q, error_d, timeout_q, timeout_d;
  logic             in_xfer_c;

  assign in_xfer_c = (state_q == S_REQ) || (state_q == S_XFER) || (state_q == S_WAIT_ACK);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    frame_d   = frame_q;
    c_oe_d    = c_oe_q;
    d_oe_d    = d_oe_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.STB && bus.WE) begin
          // Frame shifted out LSB first: data[7:0], odd parity, stop
          frame_d   = {1'b1, ~^bus.din[7:0], bus.din[7:0]};
          state_d   = S_INHIBIT;
          cnt_d     = '0;
          bitcnt_d  = '0;
          c_oe_d    = 1'b1;
          d_oe_d    = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_INHIBIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Data goes low one cycle before the clock is released
        if (cnt_q == INH_PRE) d_oe_d = 1'b1;
        if (cnt_q == INH_LAST) begin
          state_d = S_REQ;
          c_oe_d  = 1'b0;
          d_oe_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_REQ, S_XFER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fall_c) begin
          cnt_d    = '0;
          d_oe_d   = ~frame_q[0];
          frame_d  = {1'b1, frame_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          state_d  = (bitcnt_q == 4'd9) ? S_WAIT_ACK : S_XFER;
        end
      end
      S_WAIT_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fall_c) begin
          cnt_d   = '0;
          done_d  = ~d_sync_q;
          error_d = d_sync_q;
          c_oe_d  = 1'b0;
          d_oe_d  = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        c_oe_d = 1'b0;
        d_oe_d = 1'b0;
        if (filt_q && d_sync_q) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        c_oe_d  = 1'b0;
        d_oe_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Device went silent: abort without waiting for the bus to go idle.
    // A fall arriving in the same cycle still counts as in time.
    if (in_xfer_c && !fall_c && (cnt_q == TO_LAST)) begin
      state_d   = S_IDLE;
      c_oe_d    = 1'b0;
      d_oe_d    = 1'b0;
      busy_d    = 1'b0;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_scan) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      frame_q   <= '0;
      c_oe_q    <= 1'b0;
      d_oe_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      frame_q   <= frame_d;
      c_oe_q    <= c_oe_d;
      d_oe_q    <= d_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
    end
  end

  logic unused_din;
  assign unused_din = ^bus.din[31:8];

  assign bus.ACK  = bus.STB;
  assign bus.dout = {28'b0, timeout_q, error_q, done_q, busy_q};
  assign bus.INT  = done_q | error_q | timeout_q;
  assign busy     = busy_q;
  assign ps2c_oe  = c_oe_q;
  assign ps2d_oe  = d_oe_q;

endmodule
